// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer:
// opcodes, the state encoding and the bus widths.
package cpu_pkg;

    localparam int OPC_W  = 3;
    localparam int ADDR_W = 13;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_RD_OP  = 4'd3,
        ST_WR_OP  = 4'd4,
        ST_JUMP   = 4'd5,
        ST_SKIP   = 4'd6,
        ST_HALT   = 4'd7
    } state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Memory-access watchdog: counts unacknowledged wait cycles and
// raises a sticky bus error when the budget runs out.
module seq_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_expired,
    output logic o_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_wait) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (o_expired) begin
            r_err <= 1'b1;
        end
    end

    assign o_expired = i_wait && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign o_bus_err = r_err;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator CPU.
// Define SEQ_TIMEOUT_EN to bound memory waits with a watchdog.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W       = cpu_pkg::OPC_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             sel_addr,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             load_acc,
    output logic             halt,
    output logic             bus_err
);

    state_t r_state;
    state_t w_next;
    state_t w_boundary;
    logic   w_wait_state;
    logic   w_timeout;

    assign w_boundary   = ena ? ST_FETCH : ST_IDLE;
    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_RD_OP) ||
                          (r_state == ST_WR_OP);

`ifdef SEQ_TIMEOUT_EN
    // Counter is held clear outside access states and on the ack cycle,
    // so it always starts from zero on entry to the next access.
    seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_wait_state || mem_ack),
        .i_wait    (w_wait_state && !mem_ack),
        .o_expired (w_timeout),
        .o_bus_err (bus_err)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC == 0) && w_wait_state;
    assign w_timeout    = 1'b0;
    assign bus_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        sel_addr    = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        load_acc    = 1'b0;
        halt        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ena) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                rd = 1'b1;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    w_next  = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                inc_pc = 1'b1;
                case (opcode)
                    OP_HLT:                         w_next = ST_HALT;
                    OP_SKZ:                         w_next = zero ? ST_SKIP : w_boundary;
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: w_next = ST_RD_OP;
                    OP_STO:                         w_next = ST_WR_OP;
                    default:                        w_next = ST_JUMP;
                endcase
            end
            ST_RD_OP: begin
                sel_addr = 1'b1;
                rd       = 1'b1;
                if (mem_ack) begin
                    load_acc = 1'b1;
                    w_next   = w_boundary;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_WR_OP: begin
                sel_addr    = 1'b1;
                wr          = 1'b1;
                datactl_ena = 1'b1;
                if (mem_ack) begin
                    w_next = w_boundary;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_JUMP: begin
                load_pc = 1'b1;
                w_next  = w_boundary;
            end
            ST_SKIP: begin
                inc_pc = 1'b1;
                w_next = w_boundary;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer: each cycle's expected output
// vector is queued by the stimulus and checked by a negedge monitor.
module tb_cpu_sequencer;

    localparam logic [9:0] E_NONE = 10'b0000000000;
    localparam logic [9:0] E_IR   = 10'b1000000000;
    localparam logic [9:0] E_INC  = 10'b0100000000;
    localparam logic [9:0] E_LPC  = 10'b0010000000;
    localparam logic [9:0] E_SEL  = 10'b0001000000;
    localparam logic [9:0] E_RD   = 10'b0000100000;
    localparam logic [9:0] E_WR   = 10'b0000010000;
    localparam logic [9:0] E_DC   = 10'b0000001000;
    localparam logic [9:0] E_ACC  = 10'b0000000100;
    localparam logic [9:0] E_HLT  = 10'b0000000010;
    localparam logic [9:0] E_BERR = 10'b0000000001;

    typedef struct {
        logic [9:0] exp;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       load_ir, inc_pc, load_pc, sel_addr, rd, wr;
    logic       datactl_ena, load_acc, halt, bus_err;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .OPC_W       (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .sel_addr    (sel_addr),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .load_acc    (load_acc),
        .halt        (halt),
        .bus_err     (bus_err)
    );

    logic [9:0] w_act;
    assign w_act = {load_ir, inc_pc, load_pc, sel_addr, rd, wr,
                    datactl_ena, load_acc, halt, bus_err};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (w_act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b expected %b (ir inc lpc sel rd wr dc acc hlt berr)",
                         e.nm, w_act, e.exp);
            end
        end
    end

    // Drive one cycle of inputs, queue the outputs expected in that cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input logic e, input logic [2:0] op, input logic z,
                       input logic a, input logic [9:0] exp, input string nm);
        exp_t item;
        ena     = e;
        opcode  = op;
        zero    = z;
        mem_ack = a;
        item.exp = exp;
        item.nm  = nm;
        q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; opcode = 3'b000; zero = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 3'b000, 0, 1, E_NONE, "reset_idle");
        rst = 1'b0;

        // JMP with ack tied high
        cyc(1, 3'b111, 0, 1, E_NONE,        "jmp_idle");
        cyc(1, 3'b111, 0, 1, E_RD | E_IR,   "jmp_fetch");
        cyc(1, 3'b111, 0, 1, E_INC,         "jmp_decode");
        cyc(1, 3'b111, 0, 1, E_LPC,         "jmp_jump");
        // LDA with ack delayed three cycles
        cyc(1, 3'b101, 0, 1, E_RD | E_IR,   "lda_fetch");
        cyc(1, 3'b101, 0, 1, E_INC,         "lda_decode");
        for (int i = 0; i < 3; i++)
            cyc(1, 3'b101, 0, 0, E_SEL | E_RD, "lda_wait");
        cyc(1, 3'b101, 0, 1, E_SEL | E_RD | E_ACC, "lda_ack");
        // SKZ taken
        cyc(1, 3'b001, 1, 1, E_RD | E_IR,   "skz1_fetch");
        cyc(1, 3'b001, 1, 1, E_INC,         "skz1_decode");
        cyc(1, 3'b001, 1, 1, E_INC,         "skz1_skip");
        // SKZ not taken: FETCH directly after DECODE
        cyc(1, 3'b001, 0, 1, E_RD | E_IR,   "skz0_fetch");
        cyc(1, 3'b001, 0, 1, E_INC,         "skz0_decode");
        cyc(1, 3'b110, 0, 0, E_RD,          "skz0_next_fetch");
        // STO, ena dropped while the write waits
        cyc(1, 3'b110, 0, 1, E_RD | E_IR,   "sto_fetch");
        cyc(1, 3'b110, 0, 1, E_INC,         "sto_decode");
        cyc(0, 3'b110, 0, 0, E_SEL | E_WR | E_DC, "sto_wait0");
        cyc(0, 3'b110, 0, 0, E_SEL | E_WR | E_DC, "sto_wait1");
        cyc(0, 3'b110, 0, 1, E_SEL | E_WR | E_DC, "sto_ack");
        cyc(0, 3'b110, 0, 1, E_NONE,        "sto_idle0");
        cyc(0, 3'b110, 0, 1, E_NONE,        "sto_idle1");
        // HLT: sticky despite ena toggling
        cyc(1, 3'b000, 0, 1, E_NONE,        "hlt_idle");
        cyc(1, 3'b000, 0, 1, E_RD | E_IR,   "hlt_fetch");
        cyc(1, 3'b000, 0, 1, E_INC,         "hlt_decode");
        for (int i = 0; i < 20; i++)
            cyc(logic'(i % 2), 3'b111, 0, 1, E_HLT, "hlt_sticky");
        rst = 1'b1;
        cyc(1, 3'b111, 0, 1, E_HLT,         "hlt_rst_edge");
        rst = 1'b0;
        cyc(0, 3'b111, 0, 1, E_NONE,        "hlt_cleared");
        // Reset in the middle of a FETCH wait
        cyc(1, 3'b010, 0, 0, E_NONE,        "mrst_idle");
        cyc(1, 3'b010, 0, 0, E_RD,          "mrst_fetch");
        rst = 1'b1;
        cyc(1, 3'b010, 0, 0, E_RD,          "mrst_assert");
        rst = 1'b0;
        cyc(0, 3'b010, 0, 0, E_NONE,        "mrst_rd_dropped");
`ifdef SEQ_TIMEOUT_EN
        // FETCH never acknowledged: halt with bus error after 16 waits
        cyc(1, 3'b010, 0, 0, E_NONE,        "to_idle");
        for (int i = 0; i < 16; i++)
            cyc(1, 3'b010, 0, 0, E_RD,      "to_wait");
        for (int i = 0; i < 3; i++)
            cyc(1, 3'b010, 0, 1, E_HLT | E_BERR, "to_halt");
        rst = 1'b1;
        cyc(0, 3'b010, 0, 0, E_HLT | E_BERR, "to_rst_edge");
        rst = 1'b0;
        cyc(0, 3'b010, 0, 0, E_NONE,        "to_cleared");
`else
        // Without the watchdog a long FETCH wait never halts
        cyc(1, 3'b010, 0, 0, E_NONE,        "nto_idle");
        for (int i = 0; i < 20; i++)
            cyc(1, 3'b010, 0, 0, E_RD,      "nto_wait");
        cyc(1, 3'b010, 0, 1, E_RD | E_IR,   "nto_ack");
`endif
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
